axi_lite_memory_model: RTL and testbench

// - Parametrised AXI4-Lite slave memory model for core simulation and SoC bring-up; successor to the fixed 2-bank mock.
// - Generalised to N word-addressed banks with configurable read latency and out-of-range error responses.
// - Write address and write data channels are accepted independently, in either order or in the same cycle.
// - Sits on the core's instruction/data AXI4-Lite port (or behind an interconnect) in benches.

---
 rtl/axi_lite_memory_model_pkg.sv | 9 +
 rtl/axi_lite_addr_decode.sv | 18 +
 rtl/axi_lite_memory_model.sv | 157 +++++++++++++++
 tb/tb_axi_lite_memory_model.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_memory_model_pkg.sv
// axi_lite_memory_model_pkg: shared response codes, read FSM states and sizing helper
package axi_lite_memory_model_pkg;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;
    function automatic int bank_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/axi_lite_addr_decode.sv
// axi_lite_addr_decode: byte address -> {bank, word, out-of-range}
module axi_lite_addr_decode #(
    parameter int ADDR_WIDTH = 32,
    parameter int LSB        = 2,
    parameter int IDX_W      = 10,
    parameter int BANK_W     = 1,
    parameter int NUM_BANKS  = 2
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [BANK_W-1:0]     o_bank,
    output logic [IDX_W-1:0]      o_word,
    output logic                  o_oor
);
    localparam int TOP = LSB + IDX_W + BANK_W;
    assign o_word = i_addr[LSB +: IDX_W];
    assign o_bank = i_addr[LSB + IDX_W +: BANK_W];
    assign o_oor  = ((i_addr >> TOP) != '0) || (int'(o_bank) >= NUM_BANKS);
endmodule

// File: rtl/axi_lite_memory_model.sv
// axi_lite_memory_model: banked AXI4-Lite slave memory with read latency and decode errors
module axi_lite_memory_model
    import axi_lite_memory_model_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int WORDS_PER_BANK = 1024,
    parameter int NUM_BANKS      = 2,
    parameter int READ_LATENCY   = 1,
    parameter bit ERR_ON_OOR     = 1'b1,
    localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]            S_AXI_AWPROT,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    input  logic [DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [STRB_WIDTH-1:0] S_AXI_WSTRB,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    output logic [1:0]            S_AXI_BRESP,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]            S_AXI_ARPROT,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP
);
    localparam int LSB    = $clog2(STRB_WIDTH);
    localparam int IDX_W  = $clog2(WORDS_PER_BANK);
    localparam int BANK_W = bank_bits(NUM_BANKS);
    localparam int MEM_W  = BANK_W + IDX_W;
    localparam int DEPTH  = NUM_BANKS * WORDS_PER_BANK;

    logic                  r_aw_held, r_w_held, r_bvalid;
    logic [ADDR_WIDTH-1:0] r_aw_addr;
    logic [DATA_WIDTH-1:0] r_w_data;
    logic [STRB_WIDTH-1:0] r_w_strb;
    logic [1:0]            r_bresp, r_rresp;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [2:0]            r_cnt;
    rd_state_t             r_state, w_state_nxt;
    logic                  w_aw_hs, w_w_hs, w_aw_have, w_w_have, w_commit, w_ar_hs;
    logic [ADDR_WIDTH-1:0] w_aw_addr;
    logic [DATA_WIDTH-1:0] w_w_data;
    logic [STRB_WIDTH-1:0] w_w_strb;
    logic [BANK_W-1:0]     w_aw_bank, w_ar_bank;
    logic [IDX_W-1:0]      w_aw_word, w_ar_word;
    logic                  w_aw_oor, w_ar_oor, w_aw_err, w_ar_err;
    logic [MEM_W-1:0]      w_aw_idx, w_ar_idx;
    logic                  w_unused;

    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // A beat arriving in the commit cycle bypasses its holding register
    assign w_aw_hs   = S_AXI_AWVALID && !r_aw_held;
    assign w_w_hs    = S_AXI_WVALID && !r_w_held;
    assign w_aw_have = r_aw_held || w_aw_hs;
    assign w_w_have  = r_w_held || w_w_hs;
    assign w_aw_addr = r_aw_held ? r_aw_addr : S_AXI_AWADDR;
    assign w_w_data  = r_w_held ? r_w_data : S_AXI_WDATA;
    assign w_w_strb  = r_w_held ? r_w_strb : S_AXI_WSTRB;
    assign w_commit  = w_aw_have && w_w_have && (!r_bvalid || S_AXI_BREADY);
    assign w_aw_err  = ERR_ON_OOR && w_aw_oor;
    assign w_ar_err  = ERR_ON_OOR && w_ar_oor;
    assign w_aw_idx  = MEM_W'(int'({w_aw_bank, w_aw_word}) % DEPTH);
    assign w_ar_idx  = MEM_W'(int'({w_ar_bank, w_ar_word}) % DEPTH);

    axi_lite_addr_decode #(
        .ADDR_WIDTH(ADDR_WIDTH), .LSB(LSB), .IDX_W(IDX_W), .BANK_W(BANK_W), .NUM_BANKS(NUM_BANKS)
    ) u_aw_dec (
        .i_addr(w_aw_addr), .o_bank(w_aw_bank), .o_word(w_aw_word), .o_oor(w_aw_oor)
    );

    axi_lite_addr_decode #(
        .ADDR_WIDTH(ADDR_WIDTH), .LSB(LSB), .IDX_W(IDX_W), .BANK_W(BANK_W), .NUM_BANKS(NUM_BANKS)
    ) u_ar_dec (
        .i_addr(S_AXI_ARADDR), .o_bank(w_ar_bank), .o_word(w_ar_word), .o_oor(w_ar_oor)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_addr <= '0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= AXI_RESP_OKAY;
        end else begin
            r_aw_held <= w_aw_have && !w_commit;
            r_w_held  <= w_w_have && !w_commit;
            if (w_aw_hs) r_aw_addr <= S_AXI_AWADDR;
            if (w_w_hs) begin
                r_w_data <= S_AXI_WDATA;
                r_w_strb <= S_AXI_WSTRB;
            end
            r_bvalid <= w_commit || (r_bvalid && !S_AXI_BREADY);
            if (w_commit) r_bresp <= w_aw_err ? AXI_RESP_DECERR : AXI_RESP_OKAY;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            r_mem <= '{default: '0};
        else if (w_commit && !w_aw_err)
            for (int b = 0; b < STRB_WIDTH; b++)
                if (w_w_strb[b]) r_mem[w_aw_idx][8*b +: 8] <= w_w_data[8*b +: 8];
    end

    assign w_ar_hs = S_AXI_ARVALID && (r_state == RD_IDLE);

    // Counter holds cycles still to wait; RESP is entered as it reaches zero
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == RD_IDLE && S_AXI_ARVALID)
            w_state_nxt = (READ_LATENCY == 1) ? RD_RESP : RD_WAIT;
        else if (r_state == RD_WAIT && r_cnt == 3'd1)
            w_state_nxt = RD_RESP;
        else if (r_state == RD_RESP && S_AXI_RREADY)
            w_state_nxt = RD_IDLE;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= RD_IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_rresp <= AXI_RESP_OKAY;
        end else begin
            r_state <= w_state_nxt;
            if (w_ar_hs) begin
                r_cnt   <= 3'(READ_LATENCY - 1);
                r_rdata <= w_ar_err ? '0 : r_mem[w_ar_idx];
                r_rresp <= w_ar_err ? AXI_RESP_DECERR : AXI_RESP_OKAY;
            end else if (r_state == RD_WAIT) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    assign S_AXI_AWREADY = !r_aw_held;
    assign S_AXI_WREADY  = !r_w_held;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = (r_state == RD_IDLE);
    assign S_AXI_RVALID  = (r_state == RD_RESP);
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
endmodule

// File: tb/tb_axi_lite_memory_model.sv
// tb_axi_lite_memory_model: directed + random checks of two shared-stimulus instances (decode-error and wrapping)
module tb_axi_lite_memory_model;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = '0;
    logic [2:0]  prot = '0;
    logic        e_awready, e_wready, e_bvalid, e_arready, e_rvalid;
    logic        w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
    logic [1:0]  e_bresp, e_rresp, w_bresp, w_rresp;
    logic [31:0] e_rdata, w_rdata;
    logic [31:0] mem_e [2048];
    logic [31:0] mem_w [2048];
    int checks = 0, fails = 0;

    always #5 clk = ~clk;

    axi_lite_memory_model #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .WORDS_PER_BANK(1024), .NUM_BANKS(2),
        .READ_LATENCY(4), .ERR_ON_OOR(1'b1)
    ) u_err (
        .CLK(clk), .RSTn(rst_n),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(e_awready), .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(prot),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(e_wready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_BVALID(e_bvalid), .S_AXI_BREADY(bready), .S_AXI_BRESP(e_bresp),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(e_arready), .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(prot),
        .S_AXI_RVALID(e_rvalid), .S_AXI_RREADY(rready), .S_AXI_RDATA(e_rdata), .S_AXI_RRESP(e_rresp)
    );

    axi_lite_memory_model #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .WORDS_PER_BANK(1024), .NUM_BANKS(2),
        .READ_LATENCY(4), .ERR_ON_OOR(1'b0)
    ) u_wrap (
        .CLK(clk), .RSTn(rst_n),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(w_awready), .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(prot),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(w_wready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_BVALID(w_bvalid), .S_AXI_BREADY(bready), .S_AXI_BRESP(w_bresp),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(w_arready), .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(prot),
        .S_AXI_RVALID(w_rvalid), .S_AXI_RREADY(rready), .S_AXI_RDATA(w_rdata), .S_AXI_RRESP(w_rresp)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < 2048; i++) begin
            mem_e[i] = '0;
            mem_w[i] = '0;
        end
    endtask

    // Byte-address view: 0..0x1FFF is implemented; the wrapping copy keeps address bits 12:2
    task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) begin
                if (a < 32'h2000) mem_e[11'(a >> 2)][8*b +: 8] = d[8*b +: 8];
                mem_w[11'(a >> 2)][8*b +: 8] = d[8*b +: 8];
            end
    endtask

    task automatic put_aw(input logic [31:0] a);
        int n = 0;
        awaddr = a;
        awvalid = 1'b1;
        while (!e_awready && n < 20) begin step(); n++; end
        chk("aw_ready_wait", 32'(n < 20), 1);
        step();
        awvalid = 1'b0;
    endtask

    task automatic put_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        wdata = d;
        wstrb = s;
        wvalid = 1'b1;
        while (!e_wready && n < 20) begin step(); n++; end
        chk("w_ready_wait", 32'(n < 20), 1);
        step();
        wvalid = 1'b0;
    endtask

    task automatic wait_b(input logic [1:0] exp_e);
        int n = 0;
        while (!e_bvalid && n < 20) begin step(); n++; end
        chk("b_wait", 32'(n < 20), 1);
        chk("bvalid_wrap", 32'(w_bvalid), 1);
        chk("bresp_err", 32'(e_bresp), 32'(exp_e));
        chk("bresp_wrap", 32'(w_bresp), 0);
        step();
        chk("b_single", 32'({e_bvalid, w_bvalid}), 0);
    endtask

    // mode 0: AW three cycles before W; 1: W before AW; 2: same cycle
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int mode);
        int n = 0;
        if (mode == 0) begin
            put_aw(a);
            chk("aw_held", 32'({e_awready, e_bvalid}), 0);
            step(); step();
            put_w(d, s);
        end else if (mode == 1) begin
            put_w(d, s);
            chk("w_held", 32'({e_wready, e_bvalid}), 0);
            step(); step();
            put_aw(a);
        end else begin
            awaddr = a; wdata = d; wstrb = s;
            awvalid = 1'b1; wvalid = 1'b1;
            while (!(e_awready && e_wready) && n < 20) begin step(); n++; end
            chk("aww_ready_wait", 32'(n < 20), 1);
            step();
            awvalid = 1'b0; wvalid = 1'b0;
        end
        mdl_write(a, d, s);
        wait_b(a < 32'h2000 ? 2'b00 : 2'b11);
    endtask

    // Called just after the AR handshake edge
    task automatic rd_tail(input logic [31:0] xe, input logic [1:0] re, input logic [31:0] xw, input int hold);
        int n = 1;
        while (!e_rvalid && n < 20) begin step(); n++; end
        chk("r_latency", n, 4);
        chk("rvalid_wrap", 32'(w_rvalid), 1);
        chk("rdata_err", e_rdata, xe);
        chk("rresp_err", 32'(e_rresp), 32'(re));
        chk("rdata_wrap", w_rdata, xw);
        chk("rresp_wrap", 32'(w_rresp), 0);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("r_hold_valid", 32'(e_rvalid), 1);
            chk("r_hold_data", e_rdata, xe);
            chk("r_hold_arready", 32'(e_arready), 0);
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
        chk("r_done", 32'({e_rvalid, w_rvalid}), 0);
        chk("ready_idle", 32'({e_awready, e_wready, e_arready, w_awready, w_wready, w_arready}), 32'h3F);
    endtask

    task automatic rd(input logic [31:0] a, input int hold);
        int n = 0;
        logic [31:0] xe, xw;
        logic [1:0] re;
        xe = (a < 32'h2000) ? mem_e[11'(a >> 2)] : 32'h0;
        re = (a < 32'h2000) ? 2'b00 : 2'b11;
        xw = mem_w[11'(a >> 2)];
        araddr = a;
        arvalid = 1'b1;
        while (!e_arready && n < 20) begin step(); n++; end
        chk("ar_ready_wait", 32'(n < 20), 1);
        step();
        arvalid = 1'b0;
        rd_tail(xe, re, xw, hold);
    endtask

    function automatic logic [31:0] gen_addr();
        int r = int'($urandom_range(0, 9));
        if (r < 7) return {19'd0, 11'($urandom_range(0, 2047)), 2'b00};
        if (r == 7) return 32'h2000 + {19'd0, 11'($urandom_range(0, 2047)), 2'b00};
        if (r == 8) return 32'h8000_0000 | {19'd0, 11'($urandom_range(0, 2047)), 2'b00};
        return {19'd0, 13'($urandom_range(0, 8191))};
    endfunction

    initial begin
        logic [31:0] a, oe, ow;
        mdl_clear();
        step(); step(); step();
        chk("rst_ready", 32'({e_awready, e_wready, e_arready}), 32'h7);
        chk("rst_valid", 32'({e_bvalid, e_rvalid}), 0);
        chk("rst_resp", 32'({e_bresp, e_rresp}), 0);
        chk("rst_rdata", e_rdata, 0);
        rst_n = 1'b1;
        step();

        wr(32'h8, 32'hDEAD_BEEF, 4'hF, 0);
        rd(32'h8, 0);
        wr(32'h8, 32'h0BAD_CAFE, 4'hF, 1);
        rd(32'h8, 0);
        wr(32'h8, 32'h1357_9BDF, 4'hF, 2);
        rd(32'h8, 0);

        wr(32'h1004, 32'h1122_3344, 4'b0101, 2);
        rd(32'h1004, 0);
        chk("strobe_merge", e_rdata, 32'h0022_0044);
        rd(32'h0004, 0);
        rd(32'h1004, 5);

        wr(32'h2000, 32'hA5A5_5A5A, 4'hF, 2);
        rd(32'h2000, 0);
        rd(32'h0000, 0);

        a = 32'h8;
        oe = mem_e[2];
        ow = mem_w[2];
        awaddr = a; araddr = a; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        mdl_write(a, 32'hCAFE_F00D, 4'hF);
        chk("same_edge_bvalid", 32'(e_bvalid), 1);
        chk("same_edge_bresp", 32'(e_bresp), 0);
        rd_tail(oe, 2'b00, ow, 0);
        rd(a, 0);

        bready = 1'b0;
        awaddr = 32'h100; wdata = 32'h1; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        mdl_write(32'h100, 32'h1, 4'hF);
        chk("bp_first", 32'({e_bvalid, e_awready, e_wready}), 32'h7);
        awaddr = 32'h104; wdata = 32'h2;
        step();
        mdl_write(32'h104, 32'h2, 4'hF);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bp_full", 32'({e_awready, e_wready, w_awready, w_wready}), 0);
        step(); step();
        chk("bp_still_full", 32'({e_bvalid, e_awready, e_wready}), 32'h4);
        chk("bp_resp1", 32'(e_bresp), 0);
        awaddr = 32'h2004; wdata = 32'h3; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        step();
        chk("bp_resp2", 32'({e_bvalid, e_bresp, e_awready}), 32'h9);
        step();
        mdl_write(32'h2004, 32'h3, 4'hF);
        chk("bp_resp3", 32'({e_bvalid, e_bresp, w_bresp}), 32'h1C);
        awaddr = 32'h108; wdata = 32'h4;
        step();
        mdl_write(32'h108, 32'h4, 4'hF);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bp_resp4", 32'({e_bvalid, e_bresp}), 32'h4);
        step();
        chk("bp_drained", 32'({e_bvalid, w_bvalid}), 0);
        rd(32'h104, 0);
        rd(32'h2004, 0);
        rd(32'h0004, 0);

        for (int k = 0; k < 25; k++) begin
            a = gen_addr();
            wr(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
            rd(($urandom_range(0, 1) == 1) ? a : gen_addr(), int'($urandom_range(0, 2)));
        end

        araddr = 32'h8; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        step();
        awaddr = 32'h10; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        chk("pre_rst_state", 32'({e_awready, e_arready, e_rvalid}), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ready", 32'({e_awready, e_wready, e_arready, w_awready, w_wready, w_arready}), 32'h3F);
        chk("async_rst_valid", 32'({e_bvalid, e_rvalid, w_bvalid, w_rvalid}), 0);
        chk("async_rst_rdata", e_rdata, 0);
        step(); step();
        rst_n = 1'b1;
        mdl_clear();
        for (int i = 0; i < 8; i++) begin
            step();
            chk("no_stray", 32'({e_bvalid, e_rvalid, w_bvalid, w_rvalid}), 0);
        end
        rd(32'h8, 0);
        rd(32'h1004, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
